adc_capture_avg: RTL and testbench

Parametrised multi-channel ADC capture block, the successor of the fixed 8-bit, 3-stage ADC input register chain.
- Registers NUM_CH parallel ADC buses through a configurable-depth input pipeline.
- Averages each channel over 2^DECIM_LOG2 samples (boxcar decimation).
- Presents results on a valid/ready interface, with overrun flagging and a transfer counter.
- Sits between the ADC input pins and downstream logic (LED/debug outputs, capture cores).

---
 rtl/adc_capture_avg.sv | 128 ++++++++++++
 tb/tb_adc_capture_avg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_avg.sv
// Multi-channel ADC capture: input pipeline, boxcar decimation, valid/ready output with overrun flag.
// Define ADC_SIGNED_EN to treat samples as offset binary and produce two's-complement averages.
module adc_capture_avg #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned SYNC_DEPTH = 3,
   parameter int unsigned DECIM_LOG2 = 2,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                     clk_pin_p,
   input  logic                     rst_pin,
   input  logic [NUM_CH*DATA_W-1:0] adc_in,
   input  logic                     adc_en,
   input  logic                     out_ready,
   input  logic                     overrun_clr,
   output logic [NUM_CH*DATA_W-1:0] avg_out,
   output logic                     out_valid,
   output logic                     overrun,
   output logic [CNT_W-1:0]         sample_cnt
);

   localparam int unsigned BUS_W = NUM_CH * DATA_W;
   localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;
   localparam int unsigned PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);

   logic [BUS_W-1:0] pipe_q [SYNC_DEPTH];
   logic             en_q   [SYNC_DEPTH];
   logic [ACC_W-1:0] acc_q  [NUM_CH];
   logic [ACC_W-1:0] acc_d  [NUM_CH];
   logic [ACC_W-1:0] sum_c  [NUM_CH];
   logic [PH_W-1:0]  phase_q;
   logic [PH_W-1:0]  phase_d;
   logic [BUS_W-1:0] res_c;
   logic [BUS_W-1:0] s_last_c;
   logic             en_last_c;
   logic             blk_done_c;
   logic             accept_c;
   logic [BUS_W-1:0] avg_d;
   logic             valid_d;
   logic             ovr_d;
   logic [CNT_W-1:0] cnt_d;

   // Data and enable travel together; the pipeline shifts every cycle.
   always_ff @(posedge clk_pin_p or negedge rst_pin) begin
      if (!rst_pin) begin
         for (int i = 0; i < SYNC_DEPTH; i++) begin
            pipe_q[i] <= '0;
            en_q[i]   <= 1'b0;
         end
      end else begin
         pipe_q[0] <= adc_in;
         en_q[0]   <= adc_en;
         for (int i = 1; i < SYNC_DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
            en_q[i]   <= en_q[i-1];
         end
      end
   end

   assign s_last_c   = pipe_q[SYNC_DEPTH-1];
   assign en_last_c  = en_q[SYNC_DEPTH-1];
   assign blk_done_c = en_last_c && (phase_q == PH_LAST);
   assign accept_c   = out_valid && out_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DATA_W-1:0] samp;
      logic [ACC_W-1:0]  samp_ext;
`ifdef ADC_SIGNED_EN
      // Offset binary to two's complement is an MSB flip.
      assign samp     = s_last_c[k*DATA_W +: DATA_W] ^ (DATA_W'(1) << (DATA_W - 1));
      assign samp_ext = ACC_W'($signed(samp));
      assign sum_c[k] = acc_q[k] + samp_ext;
      assign res_c[k*DATA_W +: DATA_W] = DATA_W'($signed(sum_c[k]) >>> DECIM_LOG2);
`else
      assign samp     = s_last_c[k*DATA_W +: DATA_W];
      assign samp_ext = ACC_W'(samp);
      assign sum_c[k] = acc_q[k] + samp_ext;
      assign res_c[k*DATA_W +: DATA_W] = DATA_W'(sum_c[k] >> DECIM_LOG2);
`endif
   end

   // Accumulate while enabled; a completed block or an enable gap restarts from zero.
   always_comb begin
      phase_d = '0;
      for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
      if (en_last_c && !blk_done_c) begin
         phase_d = phase_q + PH_W'(1);
         for (int k = 0; k < NUM_CH; k++) acc_d[k] = sum_c[k];
      end
   end

   // Output handshake: a result loads only into a free or draining slot, otherwise it is dropped.
   always_comb begin
      avg_d   = avg_out;
      valid_d = out_valid;
      ovr_d   = overrun;
      cnt_d   = sample_cnt;
      if (accept_c) cnt_d = sample_cnt + CNT_W'(1);
      if (blk_done_c && (!out_valid || out_ready)) begin
         avg_d   = res_c;
         valid_d = 1'b1;
      end else if (accept_c) begin
         valid_d = 1'b0;
      end
      if (blk_done_c && out_valid && !out_ready) ovr_d = 1'b1;
      else if (overrun_clr)                      ovr_d = 1'b0;
   end

   always_ff @(posedge clk_pin_p or negedge rst_pin) begin
      if (!rst_pin) begin
         for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
         phase_q    <= '0;
         avg_out    <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         sample_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
         phase_q    <= phase_d;
         avg_out    <= avg_d;
         out_valid  <= valid_d;
         overrun    <= ovr_d;
         sample_cnt <= cnt_d;
      end
   end

endmodule

// File: tb/tb_adc_capture_avg.sv
// Directed bench for adc_capture_avg with default parameters.
module tb_adc_capture_avg;

   logic        clk_pin_p = 1'b0;
   logic        clk_run   = 1'b1;
   logic        rst_pin;
   logic [15:0] adc_in;
   logic        adc_en;
   logic        out_ready;
   logic        overrun_clr;
   logic [15:0] avg_out;
   logic        out_valid;
   logic        overrun;
   logic [7:0]  sample_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   adc_capture_avg dut (
      .clk_pin_p  (clk_pin_p),
      .rst_pin    (rst_pin),
      .adc_in     (adc_in),
      .adc_en     (adc_en),
      .out_ready  (out_ready),
      .overrun_clr(overrun_clr),
      .avg_out    (avg_out),
      .out_valid  (out_valid),
      .overrun    (overrun),
      .sample_cnt (sample_cnt)
   );

   initial begin
      forever begin
         #5;
         if (clk_run) clk_pin_p = ~clk_pin_p;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one sample, then advance past the next rising edge.
   task automatic send(input logic [7:0] c0, input logic [7:0] c1, input logic en);
      adc_in = {c1, c0};
      adc_en = en;
      @(posedge clk_pin_p);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) send(8'd0, 8'd0, 1'b0);
   endtask

   task automatic run4(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                       input logic [7:0] a3, input logic [7:0] b);
      send(a0, b, 1'b1);
      send(a1, b, 1'b1);
      send(a2, b, 1'b1);
      send(a3, b, 1'b1);
   endtask

   initial begin
      rst_pin     = 1'b1;
      adc_in      = '0;
      adc_en      = 1'b0;
      out_ready   = 1'b1;
      overrun_clr = 1'b0;
      #1 rst_pin = 1'b0;
      #1;
      chk("rst_avg",   32'(avg_out),    0);
      chk("rst_valid", 32'(out_valid),  0);
      chk("rst_ovr",   32'(overrun),    0);
      chk("rst_cnt",   32'(sample_cnt), 0);
      @(posedge clk_pin_p);
      @(posedge clk_pin_p);
      #1 rst_pin = 1'b1;
      idle(3);
      chk("post_rst_valid", 32'(out_valid), 0);

      // Basic average: 10,20,30,40 -> 25; ch1 constant 255
      run4(8'd10, 8'd20, 8'd30, 8'd40, 8'd255);
      idle(2);
      chk("lat_early_valid", 32'(out_valid), 0);
      idle(1);
      chk("basic_valid", 32'(out_valid), 1);
      chk("basic_ch0",   32'(avg_out[7:0]), 25);
      chk("basic_ch1",   32'(avg_out[15:8]), 255);
      chk("basic_cnt0",  32'(sample_cnt), 0);
      idle(1);
      chk("basic_pulse", 32'(out_valid), 0);
      chk("basic_cnt1",  32'(sample_cnt), 1);
      chk("basic_hold",  32'(avg_out[7:0]), 25);

      // Truncation: 5/4 -> 1, 1019/4 -> 254
      run4(8'd1, 8'd1, 8'd1, 8'd2, 8'd0);
      idle(3);
      chk("trunc1_valid", 32'(out_valid), 1);
      chk("trunc1_ch0",   32'(avg_out[7:0]), 1);
      chk("trunc1_ch1",   32'(avg_out[15:8]), 0);
      idle(1);
      chk("trunc1_cnt",   32'(sample_cnt), 2);
      run4(8'd255, 8'd255, 8'd255, 8'd254, 8'd7);
      idle(3);
      chk("trunc2_ch0",   32'(avg_out[7:0]), 254);
      chk("trunc2_ch1",   32'(avg_out[15:8]), 7);
      idle(1);
      chk("trunc2_cnt",   32'(sample_cnt), 3);

      // Backpressure: second block dropped, first held
      out_ready = 1'b0;
      run4(8'd10, 8'd20, 8'd30, 8'd40, 8'd0);
      run4(8'd50, 8'd50, 8'd50, 8'd50, 8'd0);
      chk("bp_valid_held", 32'(out_valid), 1);
      idle(2);
      chk("bp_ovr_early",  32'(overrun), 0);
      idle(1);
      chk("bp_ovr_set",    32'(overrun), 1);
      chk("bp_ch0_held",   32'(avg_out[7:0]), 25);
      chk("bp_cnt_held",   32'(sample_cnt), 3);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      chk("bp_acc_valid",  32'(out_valid), 0);
      chk("bp_acc_cnt",    32'(sample_cnt), 4);
      chk("bp_ovr_sticky", 32'(overrun), 1);
      overrun_clr = 1'b1;
      idle(1);
      overrun_clr = 1'b0;
      chk("bp_ovr_clr",    32'(overrun), 0);

      // Set and clear of overrun on the same edge: set wins
      run4(8'd10, 8'd20, 8'd30, 8'd40, 8'd0);
      run4(8'd50, 8'd50, 8'd50, 8'd50, 8'd0);
      overrun_clr = 1'b1;
      idle(2);
      chk("sw_ovr_pre",    32'(overrun), 0);
      idle(1);
      chk("sw_set_wins",   32'(overrun), 1);
      idle(1);
      overrun_clr = 1'b0;
      chk("sw_clr_after",  32'(overrun), 0);
      out_ready = 1'b1;
      idle(1);
      chk("sw_cnt",        32'(sample_cnt), 5);
      chk("sw_valid",      32'(out_valid), 0);

      // Enable gap discards the partial block
      send(8'd5, 8'd100, 1'b1);
      send(8'd5, 8'd100, 1'b1);
      send(8'd99, 8'd99, 1'b0);
      for (int i = 0; i < 4; i++) begin
         send(8'd8, 8'd100, 1'b1);
         chk("gap_no_early", 32'(out_valid), 0);
      end
      idle(2);
      chk("gap_no_early2", 32'(out_valid), 0);
      idle(1);
      chk("gap_valid", 32'(out_valid), 1);
      chk("gap_ch0",   32'(avg_out[7:0]), 8);
      chk("gap_ch1",   32'(avg_out[15:8]), 100);
      idle(1);
      chk("gap_cnt",   32'(sample_cnt), 6);
      idle(2);
      chk("gap_single", 32'(sample_cnt), 6);

      // Offset-binary zero is -128 when signed, 0 when unsigned
      run4(8'd0, 8'd0, 8'd0, 8'd0, 8'h80);
      idle(3);
`ifdef ADC_SIGNED_EN
      chk("sgn_ch0", 32'(avg_out[7:0]), 32'h80);
      chk("sgn_ch1", 32'(avg_out[15:8]), 32'h00);
`else
      chk("sgn_ch0", 32'(avg_out[7:0]), 32'h00);
      chk("sgn_ch1", 32'(avg_out[15:8]), 32'h80);
`endif
      idle(1);
      chk("sgn_cnt", 32'(sample_cnt), 7);

      // Asynchronous reset mid-block with the clock stopped
      out_ready = 1'b0;
      run4(8'd10, 8'd20, 8'd30, 8'd40, 8'd3);
      run4(8'd50, 8'd50, 8'd50, 8'd50, 8'd3);
      idle(3);
      chk("ar_pre_valid", 32'(out_valid), 1);
      chk("ar_pre_ovr",   32'(overrun), 1);
      chk("ar_pre_ch0",   32'(avg_out[7:0]), 25);
      run4(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
      clk_run = 1'b0;
      #20;
      rst_pin = 1'b0;
      #1;
      chk("ar_avg",   32'(avg_out),    0);
      chk("ar_valid", 32'(out_valid),  0);
      chk("ar_ovr",   32'(overrun),    0);
      chk("ar_cnt",   32'(sample_cnt), 0);
      #10;
      clk_run = 1'b1;
      @(posedge clk_pin_p);
      #1 rst_pin = 1'b1;
      out_ready = 1'b1;
      idle(6);
      chk("ar_stay_valid", 32'(out_valid), 0);
      chk("ar_stay_avg",   32'(avg_out), 0);
      chk("ar_stay_cnt",   32'(sample_cnt), 0);
      run4(8'd4, 8'd4, 8'd4, 8'd8, 8'd2);
      idle(2);
      chk("ar_blk_early", 32'(out_valid), 0);
      idle(1);
      chk("ar_blk_valid", 32'(out_valid), 1);
      chk("ar_blk_ch0",   32'(avg_out[7:0]), 5);
      chk("ar_blk_ch1",   32'(avg_out[15:8]), 2);
      idle(1);
      chk("ar_blk_cnt",   32'(sample_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
